// File: rtl/pa_soc_loader_pkg.sv
// pa_soc_loader_pkg: shared constants and state encodings for the UART boot loader
package pa_soc_loader_pkg;
    localparam logic [7:0] LOADER_SYNC = 8'hA5;
    localparam int DEFAULT_BAUD = 115200;
    localparam int DEFAULT_CLK_FREQ_HZ = 50_000_000;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {LD_WAIT_SYNC, LD_LOAD, LD_CHECK} ld_state_t;
endpackage

// File: rtl/pa_soc_uart_rx.sv
// pa_soc_uart_rx: 8N1 receiver with input synchronizer, start-bit confirmation and stop-bit check
module pa_soc_uart_rx
    import pa_soc_loader_pkg::*;
#(
    parameter int DIV = 10
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       rxd_i,
    output logic       byte_vld,
    output logic [7:0] rx_byte,
    output logic       frm_err
);
    localparam int CW = $clog2(DIV);
    logic sync1, sync2, prev;
    logic [CW-1:0] cnt;
    logic [2:0] bit_idx;
    logic [7:0] shreg;
    logic tick, fall;
    rx_state_t state, state_nxt;

    assign fall = prev & ~sync2;
    assign tick = (state == RX_START) ? (cnt == CW'(DIV / 2 - 1)) : (cnt == CW'(DIV - 1));
    assign rx_byte = shreg;

    // two-stage synchronizer plus one delay stage for falling-edge detection; idle level is high
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            prev  <= 1'b1;
        end else begin
            sync1 <= rxd_i;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    // receiver state register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state <= RX_IDLE;
        else state <= state_nxt;
    end

    // next state: confirm start at half a bit, then 8 data bits and the stop bit one bit apart
    always_comb begin
        state_nxt = state;
        case (state)
            RX_IDLE:  state_nxt = fall ? RX_START : RX_IDLE;
            RX_START: state_nxt = !tick ? RX_START : (sync2 ? RX_IDLE : RX_DATA);
            RX_DATA:  state_nxt = (tick && bit_idx == 3'd7) ? RX_STOP : RX_DATA;
            RX_STOP:  state_nxt = tick ? RX_IDLE : RX_STOP;
            default:  state_nxt = RX_IDLE;
        endcase
    end

    // bit timer, bit index and LSB-first shift register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            cnt <= (state == RX_IDLE || tick) ? '0 : cnt + 1'b1;
            if (state == RX_START) bit_idx <= '0;
            if (state == RX_DATA && tick) begin
                shreg   <= {sync2, shreg[7:1]};
                bit_idx <= bit_idx + 1'b1;
            end
        end
    end

    // outputs: a valid stop bit delivers the byte, a low stop bit reports a framing error
    always_comb begin
        byte_vld = (state == RX_STOP) && tick && sync2;
        frm_err  = (state == RX_STOP) && tick && !sync2;
    end
endmodule

// File: rtl/pa_soc_loader.sv
// pa_soc_loader: receives a framed image over UART, writes instruction memory and releases the CPU on a good checksum
module pa_soc_loader
    import pa_soc_loader_pkg::*;
#(
    parameter int CLK_FREQ_HZ = DEFAULT_CLK_FREQ_HZ,
    parameter int BAUD        = DEFAULT_BAUD,
    parameter int MEM_DEPTH   = 16,
    parameter int TIMEOUT_CYC = 16 * (CLK_FREQ_HZ / BAUD) * 10,
    parameter bit BOOT_HOLD   = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       rxd_i,
    output logic       mem_we_o,
    output logic [3:0] mem_addr_o,
    output logic [7:0] mem_wdata_o,
    output logic       cpu_rst_n_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o
);
    localparam int DIV = CLK_FREQ_HZ / BAUD;
    logic byte_vld, frm_err;
    logic [7:0] rx_byte;
    ld_state_t state, state_nxt;
    logic [3:0] count, count_d, addr_d;
    logic [7:0] sum, sum_d, wdata_d;
    logic [31:0] tmo, tmo_d;
    logic we_d, done_d, err_d, busy_d, cpu_rst_n_d;
    logic tmo_hit, abort, sync_hit;

    pa_soc_uart_rx #(.DIV(DIV)) u_rx (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .rxd_i    (rxd_i),
        .byte_vld (byte_vld),
        .rx_byte  (rx_byte),
        .frm_err  (frm_err)
    );

    assign tmo_hit  = tmo == 32'(TIMEOUT_CYC);
    assign abort    = (state != LD_WAIT_SYNC) && (frm_err || tmo_hit);
    assign sync_hit = (state == LD_WAIT_SYNC) && byte_vld && (rx_byte == LOADER_SYNC);

    // loader state register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state <= LD_WAIT_SYNC;
        else state <= state_nxt;
    end

    // next state: sync opens a frame, the last data byte moves to checksum, abort or checksum ends it
    always_comb begin
        state_nxt = state;
        case (state)
            LD_WAIT_SYNC: state_nxt = sync_hit ? LD_LOAD : LD_WAIT_SYNC;
            LD_LOAD:      state_nxt = abort ? LD_WAIT_SYNC : ((byte_vld && count == 4'(MEM_DEPTH - 1)) ? LD_CHECK : LD_LOAD);
            LD_CHECK:     state_nxt = (abort || byte_vld) ? LD_WAIT_SYNC : LD_CHECK;
            default:      state_nxt = LD_WAIT_SYNC;
        endcase
    end

    // output and datapath next values; the CPU is only ever released by a matching checksum
    always_comb begin
        we_d        = 1'b0;
        done_d      = 1'b0;
        addr_d      = mem_addr_o;
        wdata_d     = mem_wdata_o;
        err_d       = err_o;
        busy_d      = busy_o;
        cpu_rst_n_d = cpu_rst_n_o;
        count_d     = count;
        sum_d       = sum;
        tmo_d       = (state == LD_WAIT_SYNC) ? '0 : tmo + 1'b1;
        if (sync_hit) begin
            cpu_rst_n_d = 1'b0;
            busy_d      = 1'b1;
            err_d       = 1'b0;
            count_d     = '0;
            sum_d       = '0;
            tmo_d       = '0;
        end else if (abort) begin
            err_d  = 1'b1;
            busy_d = 1'b0;
        end else if (byte_vld && state == LD_LOAD) begin
            we_d    = 1'b1;
            addr_d  = count;
            wdata_d = rx_byte;
            sum_d   = sum + rx_byte;
            count_d = count + 1'b1;
            tmo_d   = '0;
        end else if (byte_vld && state == LD_CHECK) begin
            tmo_d       = '0;
            busy_d      = 1'b0;
            done_d      = rx_byte == sum;
            cpu_rst_n_d = rx_byte == sum;
            err_d       = rx_byte != sum;
        end
    end

    // registered outputs, counters and running checksum
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
            busy_o      <= 1'b0;
            cpu_rst_n_o <= !BOOT_HOLD;
            count       <= '0;
            sum         <= '0;
            tmo         <= '0;
        end else begin
            mem_we_o    <= we_d;
            mem_addr_o  <= addr_d;
            mem_wdata_o <= wdata_d;
            done_o      <= done_d;
            err_o       <= err_d;
            busy_o      <= busy_d;
            cpu_rst_n_o <= cpu_rst_n_d;
            count       <= count_d;
            sum         <= sum_d;
            tmo         <= tmo_d;
        end
    end
endmodule
